// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-setting controller:
// FSM encoding, keypad codes, digit indices and per-digit BCD limits.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] KEY_HASH = 4'd10;
  localparam logic [3:0] KEY_STAR = 4'd11;

  localparam logic [2:0] DIG_H_TEN = 3'd0;
  localparam logic [2:0] DIG_H_ONE = 3'd1;
  localparam logic [2:0] DIG_M_TEN = 3'd2;
  localparam logic [2:0] DIG_M_ONE = 3'd3;
  localparam logic [2:0] DIG_S_TEN = 3'd4;
  localparam logic [2:0] DIG_S_ONE = 3'd5;

  localparam logic [3:0] MAX_H_TEN     = 4'd2;
  localparam logic [3:0] MAX_H_ONE_20S = 4'd3;
  localparam logic [3:0] MAX_TEN       = 4'd5;
  localparam logic [3:0] MAX_ONE       = 4'd9;

  function automatic logic is_one_hot(input logic [11:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic logic [3:0] key_encode(input logic [11:0] v);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) code = 4'(i);
    end
    return code;
  endfunction

  // Hour units are limited to 3 only while the hour tens digit reads 2.
  function automatic logic [3:0] digit_max(input logic [2:0] idx, input logic [3:0] h_ten);
    logic [3:0] m;
    case (idx)
      DIG_H_TEN:            m = MAX_H_TEN;
      DIG_H_ONE:            m = (h_ten == MAX_H_TEN) ? MAX_H_ONE_20S : MAX_ONE;
      DIG_M_TEN, DIG_S_TEN: m = MAX_TEN;
      default:              m = MAX_ONE;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] get_digit(input logic [23:0] t, input logic [2:0] idx);
    logic [3:0] d;
    case (idx)
      3'd0:    d = t[23:20];
      3'd1:    d = t[19:16];
      3'd2:    d = t[15:12];
      3'd3:    d = t[11:8];
      3'd4:    d = t[7:4];
      3'd5:    d = t[3:0];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  function automatic logic [23:0] set_digit(input logic [23:0] t, input logic [2:0] idx,
                                            input logic [3:0] d);
    logic [23:0] r;
    r = t;
    case (idx)
      3'd0:    r[23:20] = d;
      3'd1:    r[19:16] = d;
      3'd2:    r[15:12] = d;
      3'd3:    r[11:8]  = d;
      3'd4:    r[7:4]   = d;
      3'd5:    r[3:0]   = d;
      default: r = t;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Keypad front end: 2-flop sync, debounce of a single one-hot key, and a
// release lockout so each press yields exactly one key_evt pulse.
module key_conditioner
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_input,
  output logic        key_evt,
  output logic [3:0]  key_code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [11:0]   key_s1;
  logic [11:0]   key_s2;
  logic [11:0]   key_last;
  logic [CW-1:0] cnt;
  logic          locked;
  logic          stable_ok;

  // While locked we wait for a quiet keypad; otherwise for one steady key.
  assign stable_ok = (key_s2 == key_last) &&
                     (locked ? (key_s2 == 12'd0) : is_one_hot(key_s2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1   <= 12'd0;
      key_s2   <= 12'd0;
      key_last <= 12'd0;
      cnt      <= '0;
      locked   <= 1'b0;
      key_evt  <= 1'b0;
      key_code <= 4'd0;
    end else begin
      key_s1   <= key_input;
      key_s2   <= key_s1;
      key_last <= key_s2;
      key_evt  <= 1'b0;
      if (!stable_ok) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        locked <= !locked;
        if (!locked) begin
          key_evt  <= 1'b1;
          key_code <= key_encode(key_s2);
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// hh:mm:ss time-setting controller: digit-entry session with range checks,
// cursor blink, and load/run control of the BCD time counter.
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ        = 1000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_input,
  input  logic        btn_set,
  input  logic [23:0] cur_time,
  output logic        load,
  output logic [23:0] load_time,
  output logic        run_en,
  output logic        set_mode,
  output logic [2:0]  cursor,
  output logic [23:0] edit_time,
  output logic [5:0]  blink_mask,
  output logic        key_err
);

  localparam int DEB_CYCLES   = CLK_HZ * DEBOUNCE_MS / 1000;
  localparam int BLINK_CYCLES = CLK_HZ * BLINK_HALF_MS / 1000;
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic          key_evt;
  logic [3:0]    key_code;
  logic          btn_s1;
  logic          btn_s2;
  logic          btn_d;
  logic          set_evt;
  state_t        state_q;
  state_t        state_d;
  logic [23:0]   edit_d;
  logic [2:0]    cursor_d;
  logic          key_err_d;
  logic          blink_restart;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEB_CYCLES)
  ) u_keys (
    .clk      (clk),
    .rst      (rst),
    .key_input(key_input),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_d  <= 1'b0;
    end else begin
      btn_s1 <= btn_set;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  assign set_evt = btn_s2 & ~btn_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EDIT;
      edit_time <= 24'd0;
      cursor    <= DIG_H_TEN;
      key_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      edit_time <= edit_d;
      cursor    <= cursor_d;
      key_err   <= key_err_d;
    end
  end

  // set_evt is checked before key_evt so a coincident key is dropped.
  always_comb begin
    state_d       = state_q;
    edit_d        = edit_time;
    cursor_d      = cursor;
    key_err_d     = 1'b0;
    blink_restart = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (set_evt) begin
          state_d       = ST_EDIT;
          edit_d        = cur_time;
          cursor_d      = DIG_H_TEN;
          blink_restart = 1'b1;
        end
      end
      ST_EDIT: begin
        if (set_evt) begin
          cursor_d      = DIG_H_TEN;
          blink_restart = 1'b1;
        end else if (key_evt) begin
          if (key_code == KEY_HASH) begin
            state_d = ST_COMMIT;
          end else if (key_code == KEY_STAR) begin
            state_d = ST_RUN;
          end else if (key_code <= MAX_ONE &&
                       key_code <= digit_max(cursor, get_digit(edit_time, DIG_H_TEN))) begin
            edit_d = set_digit(edit_time, cursor, key_code);
            // Entering hour tens 2 must not leave an hour of 24..29 behind.
            if (cursor == DIG_H_TEN && key_code == MAX_H_TEN &&
                get_digit(edit_time, DIG_H_ONE) > MAX_H_ONE_20S) begin
              edit_d = set_digit(edit_d, DIG_H_ONE, 4'd0);
            end
            cursor_d      = (cursor == DIG_S_ONE) ? DIG_H_TEN : cursor + 3'd1;
            blink_restart = 1'b1;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_EDIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (state_q != ST_EDIT || blink_restart) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign run_en     = (state_q == ST_RUN);
  assign set_mode   = (state_q == ST_EDIT);
  assign load       = (state_q == ST_COMMIT);
  assign load_time  = load ? edit_time : 24'd0;
  assign blink_mask = (set_mode && blink_on) ? (6'b000001 << cursor) : 6'b000000;

endmodule
